// File: rtl/alu_vector_checker.sv
// On-chip ALU self-test sequencer: replays stored vectors into an external ALU and checks the results.
// Define ALU_CHK_FLAGS_EN to also compare the ALU flags against the expected flags.
module alu_vector_checker #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned ALU_LAT = 1,
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned VW = 3 * WIDTH + 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vec_we,
  input  logic [IW-1:0]    vec_waddr,
  input  logic [VW-1:0]    vec_wdata,
  input  logic [CW-1:0]    num_vectors,
  input  logic             stop_on_fail,
  input  logic             start,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_count,
  output logic             fail_valid,
  output logic [IW-1:0]    fail_idx
);

  localparam int unsigned LW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_WAIT, ST_DONE} state_t;

  state_t           state, state_d;
  logic [IW-1:0]    idx, idx_d;
  logic [CW-1:0]    n_q, n_d;
  logic             stop_q, stop_d;
  logic [LW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] alu_a_d, alu_b_d;
  logic [1:0]       alu_control_d;
  logic             busy_d, done_d, pass_d, fail_valid_d;
  logic [CW-1:0]    err_count_d;
  logic [IW-1:0]    fail_idx_d;

  logic [VW-1:0]    mem [DEPTH];
  logic [VW-1:0]    vec_rd;
  logic [1:0]       rd_ctrl;
  logic [WIDTH-1:0] rd_a, rd_b, rd_res;
  logic [3:0]       rd_flags;
  logic [CW-1:0]    n_clamped;
  logic             mismatch;

  // Vector store; not reset, and frozen while a run is in progress
  always_ff @(posedge clk) begin
    if (vec_we && !busy) mem[vec_waddr] <= vec_wdata;
  end

  assign vec_rd   = mem[idx];
  assign rd_ctrl  = vec_rd[VW-1 -: 2];
  assign rd_a     = vec_rd[3*WIDTH+3 -: WIDTH];
  assign rd_b     = vec_rd[2*WIDTH+3 -: WIDTH];
  assign rd_res   = vec_rd[WIDTH+3 -: WIDTH];
  assign rd_flags = vec_rd[3:0];

  assign n_clamped = (num_vectors > CW'(DEPTH)) ? CW'(DEPTH) : num_vectors;

`ifdef ALU_CHK_FLAGS_EN
  assign mismatch = (alu_result != rd_res) || (alu_flags != rd_flags);
`else
  logic unused_flags;
  assign unused_flags = ^{alu_flags, rd_flags};
  assign mismatch = (alu_result != rd_res);
`endif

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      n_q         <= '0;
      stop_q      <= 1'b0;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_valid  <= 1'b0;
      fail_idx    <= '0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      n_q         <= n_d;
      stop_q      <= stop_d;
      cnt         <= cnt_d;
      alu_a       <= alu_a_d;
      alu_b       <= alu_b_d;
      alu_control <= alu_control_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      err_count   <= err_count_d;
      fail_valid  <= fail_valid_d;
      fail_idx    <= fail_idx_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    n_d           = n_q;
    stop_d        = stop_q;
    cnt_d         = cnt;
    alu_a_d       = alu_a;
    alu_b_d       = alu_b;
    alu_control_d = alu_control;
    err_count_d   = err_count;
    fail_valid_d  = fail_valid;
    fail_idx_d    = fail_idx;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          n_d          = n_clamped;
          stop_d       = stop_on_fail;
          err_count_d  = '0;
          fail_valid_d = 1'b0;
          fail_idx_d   = '0;
          idx_d        = '0;
          state_d      = (n_clamped == '0) ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        alu_a_d       = rd_a;
        alu_b_d       = rd_b;
        alu_control_d = rd_ctrl;
        cnt_d         = LW'(ALU_LAT);
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == LW'(1)) begin
          if (mismatch) begin
            if (err_count != '1) err_count_d = err_count + CW'(1);
            if (!fail_valid) begin
              fail_valid_d = 1'b1;
              fail_idx_d   = idx;
            end
          end
          if ((CW'(idx) == n_q - CW'(1)) || (mismatch && stop_q)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx + IW'(1);
            state_d = ST_DRIVE;
          end
        end else begin
          cnt_d = cnt - LW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_WAIT);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_count_d == '0);
  end

endmodule

// File: tb/tb_alu_vector_checker.sv
// Directed bench for alu_vector_checker with a behavioural ALU (ctrl 0 ADD, 1 SUB, 2 AND, 3 OR).
module tb_alu_vector_checker;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LAT   = 1;
  localparam int unsigned IW    = 3;
  localparam int unsigned CW    = 4;
  localparam int unsigned VW    = 3 * WIDTH + 6;

  logic             clk, rst_n;
  logic             vec_we;
  logic [IW-1:0]    vec_waddr;
  logic [VW-1:0]    vec_wdata;
  logic [CW-1:0]    num_vectors;
  logic             stop_on_fail, start;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [1:0]       alu_control;
  logic [3:0]       alu_flags;
  logic             busy, done, pass, fail_valid;
  logic [CW-1:0]    err_count;
  logic [IW-1:0]    fail_idx;

  alu_vector_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .vec_we(vec_we), .vec_waddr(vec_waddr), .vec_wdata(vec_wdata),
    .num_vectors(num_vectors), .stop_on_fail(stop_on_fail), .start(start),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_idx(fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU, flags {N,Z,C,V}; C is carry-out (no borrow) on SUB
  logic [WIDTH:0] sum;
  always_comb begin
    sum        = '0;
    alu_result = '0;
    alu_flags  = '0;
    case (alu_control)
      2'd0: sum = {1'b0, alu_a} + {1'b0, alu_b};
      2'd1: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      2'd2: sum = {1'b0, alu_a & alu_b};
      default: sum = {1'b0, alu_a | alu_b};
    endcase
    alu_result   = sum[WIDTH-1:0];
    alu_flags[3] = alu_result[WIDTH-1];
    alu_flags[2] = (alu_result == '0);
    alu_flags[1] = sum[WIDTH];
    if (alu_control == 2'd0)
      alu_flags[0] = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_result[WIDTH-1] != alu_a[WIDTH-1]);
    else if (alu_control == 2'd1)
      alu_flags[0] = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_result[WIDTH-1] != alu_a[WIDTH-1]);
  end

  int tests = 0;
  int fails = 0;
  int busy_cyc, done_lat;
  logic [VW-1:0] good [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] r, input logic [3:0] f);
    return {c, a, b, r, f};
  endfunction

  task automatic wr(input int slot, input logic [VW-1:0] d);
    @(negedge clk);
    vec_we = 1'b1; vec_waddr = IW'(slot); vec_wdata = d;
    @(negedge clk);
    vec_we = 1'b0;
  endtask

  // Pulse start (optionally with a same-cycle write), then count busy cycles until done
  task automatic run(input int num, input logic sof, input logic we, input int slot, input logic [VW-1:0] d);
    @(negedge clk);
    num_vectors = CW'(num); stop_on_fail = sof; start = 1'b1;
    vec_we = we; vec_waddr = IW'(slot); vec_wdata = d;
    @(negedge clk);
    start = 1'b0; vec_we = 1'b0;
    busy_cyc = 0; done_lat = 1;
    while (done !== 1'b1 && done_lat < 200) begin
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      done_lat++;
    end
    if (done !== 1'b1) check("run_timeout", 64'(done), 64'd1);
  endtask

  task automatic expect_run(input string tag, input int cycles, input logic p, input int err,
                            input logic fv, input int fi);
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(cycles));
    check({tag, "_done_latency"}, 64'(done_lat), 64'(cycles + 1));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'(p));
    check({tag, "_err_count"}, 64'(err_count), 64'(err));
    check({tag, "_fail_valid"}, 64'(fail_valid), 64'(fv));
    check({tag, "_fail_idx"}, 64'(fail_idx), 64'(fi));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    check({tag, "_alu_b"}, 64'(alu_b), 64'd0);
    check({tag, "_alu_control"}, 64'(alu_control), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
    check({tag, "_fail_valid"}, 64'(fail_valid), 64'd0);
    check({tag, "_fail_idx"}, 64'(fail_idx), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; vec_we = 1'b0; vec_waddr = '0; vec_wdata = '0;
    num_vectors = '0; stop_on_fail = 1'b0; start = 1'b0;
    good[0] = mkvec(2'd0, 32'd5, 32'd3, 32'd8, 4'b0000);
    good[1] = mkvec(2'd1, 32'd3, 32'd3, 32'd0, 4'b0110);
    good[2] = mkvec(2'd2, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 4'b0000);
    good[3] = mkvec(2'd3, 32'd0, 32'd0, 32'd0, 4'b0100);
    good[4] = mkvec(2'd0, 32'd10, 32'd20, 32'd30, 4'b0000);
    good[5] = mkvec(2'd1, 32'd1, 32'd2, 32'hFFFFFFFF, 4'b1000);
    good[6] = mkvec(2'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000);
    good[7] = mkvec(2'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b1001);
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) wr(i, good[i]);
    run(4, 1'b0, 1'b0, 0, '0);
    expect_run("all_good", 8, 1'b1, 0, 1'b0, 0);
    check("hold_alu_control", 64'(alu_control), 64'd3);

    wr(2, mkvec(2'd2, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0001, 4'b0000));
    run(4, 1'b0, 1'b0, 0, '0);
    expect_run("bad_v2", 8, 1'b0, 1, 1'b1, 2);

    wr(2, good[2]);
    wr(1, mkvec(2'd1, 32'd3, 32'd3, 32'd1, 4'b0110));
    wr(3, mkvec(2'd3, 32'd0, 32'd0, 32'd5, 4'b0100));
    run(4, 1'b1, 1'b0, 0, '0);
    expect_run("stop_on_fail", 4, 1'b0, 1, 1'b1, 1);
    run(4, 1'b0, 1'b0, 0, '0);
    expect_run("two_bad", 8, 1'b0, 2, 1'b1, 1);

    wr(1, good[1]);
    wr(3, good[3]);
    wr(0, mkvec(2'd0, 32'd5, 32'd3, 32'd8, 4'b1111));
    run(4, 1'b0, 1'b0, 0, '0);
`ifdef ALU_CHK_FLAGS_EN
    expect_run("bad_flags", 8, 1'b0, 1, 1'b1, 0);
`else
    expect_run("bad_flags", 8, 1'b1, 0, 1'b0, 0);
`endif

    wr(0, good[0]);
    run(0, 1'b0, 1'b0, 0, '0);
    expect_run("n_zero", 0, 1'b1, 0, 1'b0, 0);

    for (int i = 4; i < 7; i++) wr(i, good[i]);
    wr(7, mkvec(2'd0, 32'h7FFFFFFF, 32'd1, 32'h80000001, 4'b1001));
    run(DEPTH + 5, 1'b0, 1'b0, 0, '0);
    expect_run("n_over_depth", 2 * DEPTH, 1'b0, 1, 1'b1, 7);

    run(4, 1'b0, 1'b1, 0, mkvec(2'd0, 32'd5, 32'd3, 32'd9, 4'b0000));
    expect_run("write_with_start", 8, 1'b0, 1, 1'b1, 0);

    // A write attempted mid-run must be dropped
    wr(0, good[0]);
    @(negedge clk);
    num_vectors = CW'(4); stop_on_fail = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vec_we = 1'b1; vec_waddr = IW'(3); vec_wdata = mkvec(2'd3, 32'd0, 32'd0, 32'd7, 4'b0100);
    @(negedge clk);
    vec_we = 1'b0;
    for (int k = 0; k < 200 && done !== 1'b1; k++) @(negedge clk);
    check("busy_write_ignored_pass", 64'(pass), 64'd1);

    // Reset during WAIT of vector 2, then rerun from the preserved memory
    @(negedge clk);
    num_vectors = CW'(4); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_run_alu_a", 64'(alu_a), 64'h00000000FFFF0000);
    check("mid_run_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset("mid_run_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(4, 1'b0, 1'b0, 0, '0);
    expect_run("rerun", 8, 1'b1, 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_vector_checker.md
# alu_vector_checker

Synthesizable, self-checking ALU test sequencer. It holds up to DEPTH test vectors, each with control, operands, expected result and expected flags. On start it drives each vector into an external ALU, waits a programmable latency, compares the ALU's result and flags, and reports pass/fail, the error count and the first failing index. It sits beside the ALU as on-chip built-in self-test, replacing file-driven simulation benches.

## Interface
Parameters:
- WIDTH, 32, ALU operand/result width in bits.
- DEPTH, 32, number of vector slots; IW = $clog2(DEPTH), CW = $clog2(DEPTH+1).
- ALU_LAT, 1, cycles from ALU input update to result sample; legal range is ≥1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- vec_we  input  1  vector write strobe.
- vec_waddr  input  IW  vector slot index.
- vec_wdata  input  3*WIDTH+6  {ctrl[1:0], a, b, exp_result, exp_flags[3:0]}, ctrl in the MSBs.
- num_vectors  input  CW  vectors per run; sampled on start.
- stop_on_fail  input  1  end the run at the first mismatch; sampled on start.
- start  input  1  begins a run when the block is in IDLE or DONE.
- alu_a, alu_b  output  WIDTH  registered ALU operands.
- alu_control  output  2  registered ALU control.
- alu_result  input  WIDTH  ALU result.
- alu_flags  input  4  ALU flags {N,Z,C,V}.
- busy  output  1  run in progress.
- done  output  1  high in DONE.
- pass  output  1  valid while done=1; 1 means zero mismatches.
- err_count  output  CW  mismatch count; saturates at all-ones.
- fail_valid  output  1  at least one mismatch was seen in this run.
- fail_idx  output  IW  index of the first mismatching vector.

## Operation
- Vector memory has DEPTH entries and is written synchronously when vec_we=1. Writes while busy=1 are ignored. Reset does not clear the memory.
- FSM states are IDLE, DRIVE, WAIT and DONE.
- IDLE or DONE, on start=1:
  - Latch n = min(num_vectors, DEPTH) and stop_on_fail.
  - Clear err_count, fail_valid and fail_idx; set idx=0.
  - If n=0, go to DONE with pass=1. Otherwise go to DRIVE.
- DRIVE, one cycle: at the end of the cycle, register alu_a, alu_b and alu_control from mem[idx]; load wait counter = ALU_LAT; go to WAIT.
- WAIT, ALU_LAT cycles: on the final WAIT edge, compare alu_result against exp_result and alu_flags against exp_flags.
  - On mismatch: increment err_count (saturating). If fail_valid=0, set fail_valid=1 and fail_idx=idx.
  - If idx=n-1, or (mismatch and stop_on_fail), go to DONE. Otherwise idx++ and go to DRIVE.
- DONE: done=1, busy=0, pass=(err_count==0). DONE holds until the next start.
- busy=1 in DRIVE and WAIT. start is ignored while busy.
- alu_* outputs hold their last driven values in IDLE and DONE.

## Timing
- Reset values: alu_a=0, alu_b=0, alu_control=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_idx=0; state=IDLE.
- When rst_n is asserted mid-run, the run aborts immediately and all outputs take their reset values.
- Run latency:
  - busy rises one cycle after start is sampled.
  - A full run takes n*(1+ALU_LAT) cycles in DRIVE/WAIT; done rises on the edge after the last compare.
  - With n=0, done rises one cycle after start, and busy never asserts.
- The ALU sees stable inputs for ALU_LAT full cycles before sampling.
- A vec_we in the same cycle as start is accepted; that write is visible to the run.
- A start arriving in DONE clears done on the next edge.

## Configuration
- ALU_CHK_FLAGS_EN:
  - Defined: a mismatch is (alu_result != exp_result) or (alu_flags != exp_flags).
  - Undefined: only the result is compared. The exp_flags field is stored but ignored, and alu_flags is unused.

## Test plan
- Reset, then load 4 vectors: ADD 5+3=8 flags 0000; SUB 3-3=0 flags 0110; AND FFFF0000&0F0F0F0F=0F0F0000 flags 0000; OR 0|0=0 flags 0100. Use a matching ALU, ALU_LAT=1, start with n=4 -> busy for 8 cycles, done=1, pass=1, err_count=0, fail_valid=0.
- Same load, but corrupt vector 2's exp_result to 0F0F0001, stop_on_fail=0 -> done after 8 cycles, err_count=1, fail_idx=2, pass=0.
- Corrupt vectors 1 and 3, stop_on_fail=1 -> done after 4 busy cycles, err_count=1, fail_idx=1.
- Corrupt only vector 0's exp_flags to 1111 -> with ALU_CHK_FLAGS_EN, err_count=1 and fail_idx=0; without it, pass=1.
- num_vectors=0 -> done one cycle after start, pass=1, busy never high. num_vectors=DEPTH+5 -> exactly DEPTH vectors are checked.
- Assert rst_n=0 during WAIT of vector 2 -> all outputs return to reset values. A new start after reset reruns from idx 0 using the preserved memory.
